// File: rtl/wf_debounce_pkg.sv
// ---------------------------------------------------------------------------
// wf_debounce_pkg
//   Shared types and widths for the multi-channel switch debouncer.
//   - ch_state_e : per-channel press FSM state (IDLE, PRESS, HELD)
//   - STABLE_W   : width of the per-channel stable-sample counter
//   - HOLD_W     : width of the per-channel hold (tick) counter
// ---------------------------------------------------------------------------
package wf_debounce_pkg;

  localparam int STABLE_W = 4;
  localparam int HOLD_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } ch_state_e;

endpackage : wf_debounce_pkg

// File: rtl/wf_multi_debounce_if.sv
// ---------------------------------------------------------------------------
// wf_multi_debounce_if
//   Bundles the switch-side inputs and the user-side event outputs of the
//   debouncer.
//   master : drives sample_en / sw_in, observes the event outputs
//   slave  : the debouncer itself
//   Signals:
//     sample_en    sample strobe from the shared timer
//     sw_in        raw asynchronous switch pins, one per channel
//     sw_level     debounced level, 1 = pressed
//     sw_pushed    one-cycle pulse on released->pressed
//     sw_released  one-cycle pulse on pressed->released
//     sw_long      one-cycle pulse after LONG_TICKS held samples
//     sw_repeat    one-cycle pulse every REPEAT_TICKS samples after sw_long
//     sw_any       registered OR of sw_level
// ---------------------------------------------------------------------------
interface wf_multi_debounce_if #(
  parameter int NUM_CH = 4
);

  logic              sample_en;
  logic [NUM_CH-1:0] sw_in;
  logic [NUM_CH-1:0] sw_level;
  logic [NUM_CH-1:0] sw_pushed;
  logic [NUM_CH-1:0] sw_released;
  logic [NUM_CH-1:0] sw_long;
  logic [NUM_CH-1:0] sw_repeat;
  logic              sw_any;

  modport master (
    output sample_en, sw_in,
    input  sw_level, sw_pushed, sw_released, sw_long, sw_repeat, sw_any
  );

  modport slave (
    input  sample_en, sw_in,
    output sw_level, sw_pushed, sw_released, sw_long, sw_repeat, sw_any
  );

endinterface : wf_multi_debounce_if

// File: rtl/wf_debounce_ch.sv
// ---------------------------------------------------------------------------
// wf_debounce_ch
//   One switch channel: 2-FF synchronizer, polarity normalisation, stable
//   sample counter, press FSM with hold counter, registered event pulses.
//   Ports:
//     clk, rst     system clock, synchronous active-high reset
//     sample_en_i  sample strobe
//     sw_i         raw asynchronous pin
//     level_o      debounced level (1 = pressed)
//     pushed_o     pulse in the first cycle level_o shows 1
//     released_o   pulse in the first cycle level_o shows 0
//     long_o       pulse when held for LONG_TICKS samples
//     repeat_o     pulse every REPEAT_TICKS samples after long_o
// ---------------------------------------------------------------------------
module wf_debounce_ch #(
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 1,
  parameter int LONG_TICKS     = 100,
  parameter int REPEAT_TICKS   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic sw_i,
  output logic level_o,
  output logic pushed_o,
  output logic released_o,
  output logic long_o,
  output logic repeat_o
);

  import wf_debounce_pkg::*;

  // Pin value when the switch is not pressed; also the XOR that maps the
  // synchronized pin to "1 = pressed".
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

  // Counters compare against "last value before the target" so the event
  // fires on the same sample that would make the count reach the target.
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_SAMPLES - 1);
  localparam logic [HOLD_W-1:0]   LONG_LAST   = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0]   REPEAT_LAST = HOLD_W'(REPEAT_TICKS - 1);
  localparam bit                  REPEAT_ON   = (REPEAT_TICKS != 0);

  logic [1:0]          sync_q;
  logic                pressed;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic                level_q, level_d;
  logic                rise_evt, fall_evt;
  ch_state_e           state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
  logic                pushed_q, released_q, long_q, long_d, repeat_q, repeat_d;

  assign pressed  = sync_q[1] ^ PIN_IDLE;
  assign hold_inc = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);

  // Debounce: level flips once STABLE_SAMPLES consecutive samples disagree.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    stable_d = stable_q;
    level_d  = level_q;
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    if (sample_en_i) begin
      if (pressed == level_q) begin
        stable_d = '0;
      end else if (stable_q == STABLE_LAST) begin
        stable_d = '0;
        level_d  = ~level_q;
        rise_evt = ~level_q;
        fall_evt = level_q;
      end else begin
        stable_d = stable_q + STABLE_W'(1);
      end
    end
  end

  // Press FSM. A release overrides everything, so a long/repeat that would
  // land on the releasing sample is dropped.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    if (fall_evt) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_evt) begin
            state_d = PRESS;
            hold_d  = '0;
          end
        end
        PRESS: begin
          if (sample_en_i) begin
            if (hold_q == LONG_LAST) begin
              long_d  = 1'b1;
              hold_d  = '0;
              state_d = HELD;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        HELD: begin
          if (sample_en_i) begin
            if (REPEAT_ON && (hold_q == REPEAT_LAST)) begin
              repeat_d = 1'b1;
              hold_d   = '0;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= {2{PIN_IDLE}};
      stable_q   <= '0;
      level_q    <= 1'b0;
      state_q    <= IDLE;
      hold_q     <= '0;
      pushed_q   <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], sw_i};
      stable_q   <= stable_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      pushed_q   <= rise_evt;
      released_q <= fall_evt;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o    = level_q;
  assign pushed_o   = pushed_q;
  assign released_o = released_q;
  assign long_o     = long_q;
  assign repeat_o   = repeat_q;

endmodule : wf_debounce_ch

// File: rtl/wf_multi_debounce.sv
// ---------------------------------------------------------------------------
// wf_multi_debounce
//   N-channel switch debouncer/synchronizer with pushed, released, long-press
//   and auto-repeat events per channel, plus a registered "any pressed" flag.
//   Ports:
//     clk    system clock, all logic on posedge
//     rst    synchronous active-high reset
//     sw_if  wf_multi_debounce_if.slave (sample_en, sw_in in; events out)
// ---------------------------------------------------------------------------
module wf_multi_debounce #(
  parameter int NUM_CH         = 4,
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 1,
  parameter int LONG_TICKS     = 100,
  parameter int REPEAT_TICKS   = 20
) (
  input  logic                clk,
  input  logic                rst,
  wf_multi_debounce_if.slave  sw_if
);

  logic [NUM_CH-1:0] level_v, pushed_v, released_v, long_v, repeat_v;
  logic              any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wf_debounce_ch #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sample_en_i (sw_if.sample_en),
      .sw_i        (sw_if.sw_in[g]),
      .level_o     (level_v[g]),
      .pushed_o    (pushed_v[g]),
      .released_o  (released_v[g]),
      .long_o      (long_v[g]),
      .repeat_o    (repeat_v[g])
    );
  end

  // Registered so it is glitch-free; lags sw_level by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |level_v;
    end
  end

  assign sw_if.sw_level    = level_v;
  assign sw_if.sw_pushed   = pushed_v;
  assign sw_if.sw_released = released_v;
  assign sw_if.sw_long     = long_v;
  assign sw_if.sw_repeat   = repeat_v;
  assign sw_if.sw_any      = any_q;

endmodule : wf_multi_debounce

// File: tb/tb_wf_multi_debounce.sv
// ---------------------------------------------------------------------------
// tb_wf_multi_debounce
//   Directed stimulus with hand-computed expectations, plus a sample-window
//   model of the debouncer compared against the DUT on every cycle.
// ---------------------------------------------------------------------------
module tb_wf_multi_debounce;

  localparam int N  = 4;
  localparam int SS = 3;
  localparam int LT = 5;
  localparam int RT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wf_multi_debounce_if #(.NUM_CH(N)) dut_if ();

  wf_multi_debounce #(
    .NUM_CH         (N),
    .STABLE_SAMPLES (SS),
    .ACTIVE_LOW     (1),
    .LONG_TICKS     (LT),
    .REPEAT_TICKS   (RT)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .sw_if (dut_if)
  );

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Model: pressed flag reaches the sampler two clocks after the pin.
  // Level flips when the last SS samples since the previous flip all
  // disagree with it. Long/repeat follow from the number of samples
  // counted since the press.
  // ------------------------------------------------------------------
  logic [N-1:0] e_level, e_pushed, e_released, e_long, e_repeat;
  logic         e_any;
  bit           model_ok = 1'b0;
  bit           m_pipe1 [N];
  bit           m_pipe2 [N];
  logic [15:0]  m_hist  [N];
  int           m_len   [N];
  int           m_n     [N];

  function automatic bit window_differs(input logic [15:0] h, input logic lvl);
    logic [15:0] mask;
    mask = (16'd1 << SS) - 16'd1;
    return lvl ? ((h & mask) == 16'd0) : ((h & mask) == mask);
  endfunction

  task automatic model_step();
    bit p;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_pipe1[c] = 1'b0;
        m_pipe2[c] = 1'b0;
        m_hist[c]  = '0;
        m_len[c]   = 0;
        m_n[c]     = 0;
      end
      e_level = '0; e_pushed = '0; e_released = '0;
      e_long  = '0; e_repeat = '0; e_any      = 1'b0;
    end else begin
      e_any = |e_level;
      for (int c = 0; c < N; c++) begin
        p          = m_pipe2[c];
        m_pipe2[c] = m_pipe1[c];
        m_pipe1[c] = (dut_if.sw_in[c] == 1'b0);
        e_pushed[c] = 1'b0; e_released[c] = 1'b0;
        e_long[c]   = 1'b0; e_repeat[c]   = 1'b0;
        if (dut_if.sample_en) begin
          m_hist[c] = {m_hist[c][14:0], p};
          if (m_len[c] < 16) m_len[c]++;
          if (m_len[c] >= SS && window_differs(m_hist[c], e_level[c])) begin
            e_level[c] = ~e_level[c];
            m_len[c]   = 0;
            if (e_level[c]) e_pushed[c] = 1'b1;
            else            e_released[c] = 1'b1;
          end
        end
        if (e_pushed[c]) begin
          m_n[c] = 0;
        end else if (!e_released[c] && dut_if.sample_en && e_level[c]) begin
          m_n[c]++;
          if (m_n[c] == LT) e_long[c] = 1'b1;
          else if (RT != 0 && m_n[c] > LT && ((m_n[c] - LT) % RT) == 0) e_repeat[c] = 1'b1;
        end
      end
    end
    model_ok = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("cmp_level",    dut_if.sw_level,    e_level);
      check("cmp_pushed",   dut_if.sw_pushed,   e_pushed);
      check("cmp_released", dut_if.sw_released, e_released);
      check("cmp_long",     dut_if.sw_long,     e_long);
      check("cmp_repeat",   dut_if.sw_repeat,   e_repeat);
      check("cmp_any",      dut_if.sw_any,      e_any);
    end
  end

  // Two quiet clocks so a pin change set now reaches the synchronizer
  // output, then one sample clock. Returns at the negedge right after the
  // sample, where that sample's pulses are visible.
  task automatic strobe();
    @(negedge clk);
    @(negedge clk);
    dut_if.sample_en = 1'b1;
    @(negedge clk);
    dut_if.sample_en = 1'b0;
  endtask

  initial begin
    logic [N-1:0] acc_p, acc_r, acc_l;
    logic [31:0]  l_hits, r_hits;
    int           cyc;
    bit           seen;

    // 1. Reset with pins pressed and sampling every clock.
    rst              = 1'b1;
    dut_if.sample_en = 1'b1;
    dut_if.sw_in     = '0;
    repeat (3) begin
      @(negedge clk);
      check("t1_rst_level",  dut_if.sw_level,  0);
      check("t1_rst_pushed", dut_if.sw_pushed, 0);
      check("t1_rst_any",    dut_if.sw_any,    0);
    end
    rst  = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dut_if.sw_pushed != '0) seen = 1'b1;
    end
    check("t1_push_cycle", cyc, 5);
    check("t1_push_val",   dut_if.sw_pushed, 4'hF);
    dut_if.sample_en = 1'b0;
    dut_if.sw_in     = '1;
    repeat (3) strobe();
    check("t1_release", dut_if.sw_released, 4'hF);
    check("t1_level0",  dut_if.sw_level,    4'h0);

    // 2. Bounce on ch0: low, high, then stable low.
    acc_p = '0;
    for (int i = 0; i < 5; i++) begin
      dut_if.sw_in[0] = (i == 1);
      strobe();
      if (i < 4) acc_p |= dut_if.sw_pushed;
    end
    check("t2_no_early_push", acc_p, 0);
    check("t2_push",          dut_if.sw_pushed, 4'b0001);
    check("t2_level",         dut_if.sw_level,  4'b0001);

    // 3. Hold ch0 for 12 samples: long at 5, repeats at 7, 9, 11.
    l_hits = '0;
    r_hits = '0;
    for (int s = 1; s <= 12; s++) begin
      strobe();
      if (dut_if.sw_long[0])   l_hits[s] = 1'b1;
      if (dut_if.sw_repeat[0]) r_hits[s] = 1'b1;
    end
    check("t3_long_at",   l_hits, 32'h0000_0020);
    check("t3_repeat_at", r_hits, 32'h0000_0A80);
    dut_if.sw_in[0] = 1'b1;
    acc_r = '0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      if (i < 2) acc_r |= dut_if.sw_released;
    end
    check("t3_no_early_rel",   acc_r, 0);
    check("t3_release",        dut_if.sw_released, 4'b0001);
    check("t3_rel_beats_rep",  dut_if.sw_repeat,   0);

    // 4. Release so the level falls on the sample that would fire long.
    dut_if.sw_in[0] = 1'b0;
    repeat (3) strobe();
    check("t4_push", dut_if.sw_pushed, 4'b0001);
    acc_l = '0;
    repeat (2) begin
      strobe();
      acc_l |= dut_if.sw_long;
    end
    dut_if.sw_in[0] = 1'b1;
    repeat (3) begin
      strobe();
      acc_l |= dut_if.sw_long;
    end
    check("t4_release", dut_if.sw_released, 4'b0001);
    check("t4_no_long", acc_l, 0);

    // 5. ch1 and ch3 pressed together, ch2 glitches for one sample.
    dut_if.sw_in = 4'b0001;
    strobe();
    acc_p = dut_if.sw_pushed;
    dut_if.sw_in[2] = 1'b1;
    strobe();
    acc_p |= dut_if.sw_pushed;
    strobe();
    check("t5_no_early_push", acc_p, 0);
    check("t5_push",          dut_if.sw_pushed, 4'b1010);
    check("t5_any_lag",       dut_if.sw_any,    1'b0);
    @(negedge clk);
    check("t5_any",           dut_if.sw_any,    1'b1);
    check("t5_level",         dut_if.sw_level,  4'b1010);

    // 6. Reset while ch0 is in HELD; pins stay pressed.
    dut_if.sw_in[0] = 1'b0;
    repeat (3) strobe();
    check("t6_push", dut_if.sw_pushed, 4'b0001);
    acc_l = '0;
    repeat (6) begin
      strobe();
      acc_l |= dut_if.sw_long;
    end
    check("t6_long_ch0", acc_l[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_level", dut_if.sw_level, 0);
    acc_r = dut_if.sw_released;
    acc_p = '0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      acc_r |= dut_if.sw_released;
      if (i < 2) acc_p |= dut_if.sw_pushed;
    end
    check("t6_no_release",    acc_r, 0);
    check("t6_no_early_push", acc_p, 0);
    check("t6_fresh_push",    dut_if.sw_pushed, 4'b1011);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_wf_multi_debounce
